// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} rf_state_e;

  // True for a real, writable register: nonzero and below the register count.
  function automatic logic addr_ok(input logic [31:0] addr, input int nregs);
    return (addr != 32'd0) && (addr < 32'(nregs));
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: same-cycle write bypass with port priority, plus busy masking.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = 5
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     st_data,
  input  logic                st_busy,
  output logic [XLEN-1:0]     rd_data,
  output logic                rd_busy
);

  logic            ok;
  logic            hit;
  logic [XLEN-1:0] byp;

  assign ok = addr_ok(32'(rd_addr), NREGS);

  // Ascending scan so the highest-index matching port is the one left in byp.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr)) begin
        hit = 1'b1;
        byp = wr_data[p*XLEN +: XLEN];
      end
    end
  end

  assign rd_data = !ok ? '0 : (hit ? byp : st_data);
  assign rd_busy = ok && st_busy && !hit;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, busy scoreboard and a
// sequenced clear that stalls the pipeline through a ready handshake.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                clr_req,
  output logic                ready,
  output logic                clr_done
);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;
  rf_state_e                  state, state_n;
  logic [AW-1:0]              cnt, cnt_n;
  logic [NWR-1:0]             wr_en_g;

  assign wr_en_g = ready ? wr_en : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ready    = 1'b0;
    clr_done = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (clr_req) begin
          state_n = CLEAR;
          cnt_n   = AW'(1);
        end
      end
      CLEAR: begin
        cnt_n = cnt + AW'(1);
        if (cnt == AW'(NREGS - 1)) state_n = DONE;
      end
      DONE: begin
        clr_done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Issue is applied after the writes so a same-cycle issue leaves busy set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
      busy <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
      busy[cnt] <= 1'b0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_g[p] && addr_ok(32'(wr_addr[p*AW +: AW]), NREGS)) begin
          regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
          busy[wr_addr[p*AW +: AW]] <= 1'b0;
        end
      end
      if (ready && iss_en && addr_ok(32'(iss_addr), NREGS))
        busy[iss_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            ra_ok;
    logic [XLEN-1:0] st_d;
    logic            st_b;

    assign ra    = rd_addr[g*AW +: AW];
    assign ra_ok = addr_ok(32'(ra), NREGS);
    assign st_d  = ra_ok ? regs[ra] : '0;
    assign st_b  = ra_ok ? busy[ra] : 1'b0;

    rf_read_port #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .AW(AW)) u_rp (
      .wr_en   (wr_en_g),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (ra),
      .st_data (st_d),
      .st_busy (st_b),
      .rd_data (rd_data[g*XLEN +: XLEN]),
      .rd_busy (rd_busy[g])
    );
  end

endmodule
